// File: rtl/sha256d_axil_pkg.sv
// Shared constants for the sha256d core-control AXI4-Lite register block:
// register map indices, field positions and AXI response codes.
package sha256d_axil_pkg;

  localparam int CTRL_IDX     = 0;
  localparam int STATUS_IDX   = 1;
  localparam int FIRST_RW_IDX = 2;
  localparam int BUSY_OFS     = 16;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  // IRQ_EN lives in the top bit of CTRL whatever the bus width.
  function automatic int irq_en_pos(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/sha256d_axil_wstrb_merge.sv
// Byte-lane merge: each strobe bit selects the new byte, otherwise the old
// byte is kept.
module sha256d_axil_wstrb_merge #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   old_data_i,
  input  logic [DW-1:0]   new_data_i,
  input  logic [DW/8-1:0] strb_i,
  output logic [DW-1:0]   merged_o
);

  always_comb begin
    for (int b = 0; b < DW / 8; b++) begin
      merged_o[b*8 +: 8] = strb_i[b] ? new_data_i[b*8 +: 8] : old_data_i[b*8 +: 8];
    end
  end

endmodule

// File: rtl/sha256d_axil_csr.sv
// AXI4-Lite control/status block for an array of sha256d cores: start pulses,
// sticky done flags with interrupt, general RW registers and sampled RO inputs.
module sha256d_axil_csr
  import sha256d_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_CORES          = 4,
  parameter int NUM_RW             = 8,
  parameter int NUM_RO             = 8,
  localparam int C_S_AXI_ADDR_WIDTH =
    $clog2(2 + NUM_RW + NUM_RO) + $clog2(C_S_AXI_DATA_WIDTH / 8)
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [NUM_CORES-1:0]                 core_start,
  input  logic [NUM_CORES-1:0]                 core_done,
  input  logic [NUM_CORES-1:0]                 core_busy,
  output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0] rw_regs,
  input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0] ro_regs,
  output logic                                 irq
);

  localparam int DW           = C_S_AXI_DATA_WIDTH;
  localparam int NB           = DW / 8;
  localparam int AW           = C_S_AXI_ADDR_WIDTH;
  localparam int ADDR_LSB     = $clog2(NB);
  localparam int NUM_REGS     = 2 + NUM_RW + NUM_RO;
  localparam int FIRST_RO_IDX = FIRST_RW_IDX + NUM_RW;
  localparam int IRQ_EN_BIT   = irq_en_pos(DW);

  logic                         bvalid_q, bvalid_d;
  logic [1:0]                   bresp_q, bresp_d;
  logic                         rvalid_q, rvalid_d;
  logic [1:0]                   rresp_q, rresp_d;
  logic [DW-1:0]                rdata_q, rdata_d;
  logic [NUM_CORES-1:0]         core_start_q, core_start_d;
  logic [NUM_CORES-1:0]         done_q, done_d;
  logic                         irq_en_q, irq_en_d;
  logic                         irq_q, irq_d;
  logic [NUM_RW-1:0][DW-1:0]    rw_q, rw_d;

  logic                         wr_accept, rd_accept;
  logic [31:0]                  widx, ridx;
  logic                         wr_rw, wr_err;
  logic [NUM_CORES-1:0]         bit_strb, done_clr;
  logic [DW-1:0]                rw_old, rw_merged;

  // Byte-offset address bits take no part in decode.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  assign widx = 32'(S_AXI_AWADDR[AW-1:ADDR_LSB]);
  assign ridx = 32'(S_AXI_ARADDR[AW-1:ADDR_LSB]);

  assign wr_accept = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !S_AXI_ARESET;
  assign rd_accept = S_AXI_ARVALID && !rvalid_q && !S_AXI_ARESET;

  assign wr_rw  = (widx >= FIRST_RW_IDX) && (widx < FIRST_RO_IDX);
  assign wr_err = (widx >= FIRST_RO_IDX);

  always_comb begin
    rw_old = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      if (widx == 32'(FIRST_RW_IDX + k)) rw_old = rw_q[k];
    end
    for (int i = 0; i < NUM_CORES; i++) bit_strb[i] = S_AXI_WSTRB[i/8];
  end

  sha256d_axil_wstrb_merge #(.DW(DW)) u_merge (
    .old_data_i (rw_old),
    .new_data_i (S_AXI_WDATA),
    .strb_i     (S_AXI_WSTRB),
    .merged_o   (rw_merged)
  );

  always_comb begin
    // NOTE: every _d gets its default first, so no path through this block
    // leaves a variable unassigned and infers a latch.
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    core_start_d = '0;
    irq_en_d     = irq_en_q;
    rw_d         = rw_q;
    done_clr     = '0;

    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (wr_accept) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
      if (widx == CTRL_IDX) begin
        core_start_d = S_AXI_WDATA[NUM_CORES-1:0] & bit_strb;
        if (S_AXI_WSTRB[NB-1]) irq_en_d = S_AXI_WDATA[IRQ_EN_BIT];
      end else if (widx == STATUS_IDX) begin
        done_clr = S_AXI_WDATA[NUM_CORES-1:0] & bit_strb;
      end else if (wr_rw) begin
        for (int k = 0; k < NUM_RW; k++) begin
          if (widx == 32'(FIRST_RW_IDX + k)) rw_d[k] = rw_merged;
        end
      end
    end

    // A completion arriving with a clear keeps the flag set.
    done_d = (done_q & ~done_clr) | core_done;
    irq_d  = irq_en_q && (|done_q);

    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (rd_accept) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      rdata_d  = '0;
      if (ridx == CTRL_IDX) begin
        rdata_d[IRQ_EN_BIT] = irq_en_q;
      end else if (ridx == STATUS_IDX) begin
        rdata_d[NUM_CORES-1:0]          = done_q;
        rdata_d[BUSY_OFS +: NUM_CORES]  = core_busy;
      end else if (ridx < NUM_REGS) begin
        for (int k = 0; k < NUM_RW; k++) begin
          if (ridx == 32'(FIRST_RW_IDX + k)) rdata_d = rw_q[k];
        end
        for (int k = 0; k < NUM_RO; k++) begin
          if (ridx == 32'(FIRST_RO_IDX + k)) rdata_d = ro_regs[k*DW +: DW];
        end
      end else begin
        rresp_d = RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    // NOTE: state updates here use non-blocking assignments only; all
    // next-state arithmetic stays in the always_comb above.
    if (S_AXI_ARESET) begin
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
      core_start_q <= '0;
      done_q       <= '0;
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
      // NOTE: the RW register file is plain flops, so it is cleared on reset
      // like the rest of the state.
      rw_q         <= '0;
    end else begin
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      core_start_q <= core_start_d;
      done_q       <= done_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
      rw_q         <= rw_d;
    end
  end

  assign S_AXI_AWREADY = wr_accept;
  assign S_AXI_WREADY  = wr_accept;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = rd_accept;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign core_start    = core_start_q;
  assign irq           = irq_q;
  assign rw_regs       = rw_q;

endmodule
